warp_barrier_ctrl: RTL and testbench

- Barrier controller for the warp scheduler.
- Owns all per-barrier state: arrival counters, arrived-warp masks and global-barrier sequencing.
- The scheduler forwards barrier instructions from the warp-control path; this block returns a per-warp release mask that the scheduler uses to clear stalled warps.
- Arbitrates among barriers competing for the single cluster-level global-barrier request channel.

---
 rtl/warp_barrier_ctrl_if.sv | 44 ++++
 rtl/warp_barrier_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_warp_barrier_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_barrier_ctrl_if.sv
// Port bundle for warp_barrier_ctrl: scheduler arrivals/releases, status, and the
// cluster-level global-barrier request/response channel.
interface warp_barrier_ctrl_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NUM_CORES    = 1
);
  localparam int NW_WIDTH = (NUM_WARPS    > 1) ? $clog2(NUM_WARPS)    : 1;
  localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int NC_WIDTH = (NUM_CORES    > 1) ? $clog2(NUM_CORES)    : 1;

  logic                 arr_valid;
  logic [NW_WIDTH-1:0]  arr_wid;
  logic [NB_WIDTH-1:0]  arr_id;
  logic [NW_WIDTH-1:0]  arr_size_m1;
  logic                 arr_is_global;
  logic                 arr_is_noop;
  logic [NUM_WARPS-1:0] active_warps;
  logic                 release_valid;
  logic [NUM_WARPS-1:0] release_mask;
  logic                 gbar_req_valid;
  logic                 gbar_req_ready;
  logic [NB_WIDTH-1:0]  gbar_req_id;
  logic [NC_WIDTH-1:0]  gbar_req_size_m1;
  logic [NC_WIDTH-1:0]  gbar_req_core_id;
  logic                 gbar_rsp_valid;
  logic [NB_WIDTH-1:0]  gbar_rsp_id;
  logic                 error;
  logic                 busy;

  modport master (
    output arr_valid, arr_wid, arr_id, arr_size_m1, arr_is_global, arr_is_noop,
           active_warps, gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
    input  release_valid, release_mask, gbar_req_valid, gbar_req_id,
           gbar_req_size_m1, gbar_req_core_id, error, busy
  );

  modport slave (
    input  arr_valid, arr_wid, arr_id, arr_size_m1, arr_is_global, arr_is_noop,
           active_warps, gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
    output release_valid, release_mask, gbar_req_valid, gbar_req_id,
           gbar_req_size_m1, gbar_req_core_id, error, busy
  );
endinterface

// File: rtl/warp_barrier_ctrl.sv
// Warp barrier controller: per-barrier arrival tracking, release masks and global-barrier
// sequencing. The global path (GREQ/GWAIT states, request arbiter) exists only with BAR_GLOBAL_EN.
module warp_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NUM_CORES    = 1,
  parameter int CORE_ID      = 0
) (
  input logic                clk,
  input logic                reset,
  warp_barrier_ctrl_if.slave bus
);
  localparam int NW_WIDTH = (NUM_WARPS    > 1) ? $clog2(NUM_WARPS)    : 1;
  localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int NC_WIDTH = (NUM_CORES    > 1) ? $clog2(NUM_CORES)    : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1
`ifdef BAR_GLOBAL_EN
    ,
    GREQ    = 2'd2,
    GWAIT   = 2'd3
`endif
  } state_e;

  state_e               state_q [NUM_BARRIERS];
  state_e               state_d [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  ctr_q   [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  ctr_d   [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_q  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_d  [NUM_BARRIERS];

  logic [NUM_WARPS-1:0] arr_bit;
  logic                 arr_open;
  logic [NUM_WARPS-1:0] release_mask_d, release_mask_q;
  logic                 release_valid_q;
  logic                 err_set, error_q;
  logic                 busy_d, busy_q;

`ifdef BAR_GLOBAL_EN
  logic [NC_WIDTH-1:0]  size_q [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  size_d [NUM_BARRIERS];
  logic                 req_valid_d, req_valid_q;
  logic [NB_WIDTH-1:0]  req_id_d, req_id_q;
  logic [NC_WIDTH-1:0]  req_size_d, req_size_q;
  logic                 req_fire, any_wait, any_greq;
  logic [NB_WIDTH-1:0]  greq_sel;
`else
  logic unused_gbar;
  assign unused_gbar = ^{bus.arr_is_global, bus.active_warps, bus.gbar_req_ready,
                         bus.gbar_rsp_valid, bus.gbar_rsp_id, NC_WIDTH'(CORE_ID % NUM_CORES)};
`endif

  always_comb begin
    state_d        = state_q;
    ctr_d          = ctr_q;
    mask_d         = mask_q;
    release_mask_d = '0;
    err_set        = 1'b0;
    busy_d         = 1'b0;
    arr_bit        = NUM_WARPS'(1) << bus.arr_wid;
    arr_open       = (state_q[bus.arr_id] == IDLE) || (state_q[bus.arr_id] == COLLECT);
`ifdef BAR_GLOBAL_EN
    size_d      = size_q;
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    req_size_d  = req_size_q;
    req_fire    = req_valid_q && bus.gbar_req_ready;
    any_wait    = 1'b0;
    any_greq    = 1'b0;
    greq_sel    = '0;
`endif

    // Arrival decisions use registered state, so events on different barriers never collide.
    if (bus.arr_valid) begin
      if (bus.arr_is_noop) begin
        release_mask_d = release_mask_d | arr_bit;
      end else if (!arr_open || ((mask_q[bus.arr_id] & arr_bit) != '0)) begin
        err_set = 1'b1;
`ifdef BAR_GLOBAL_EN
      end else if (bus.arr_is_global) begin
        mask_d[bus.arr_id] = mask_q[bus.arr_id] | arr_bit;
        if ((mask_q[bus.arr_id] | arr_bit) == bus.active_warps) begin
          state_d[bus.arr_id] = GREQ;
          size_d[bus.arr_id]  = NC_WIDTH'(bus.arr_size_m1);
        end else begin
          state_d[bus.arr_id] = COLLECT;
        end
`endif
      end else if (ctr_q[bus.arr_id] == bus.arr_size_m1) begin
        release_mask_d      = release_mask_d | mask_q[bus.arr_id] | arr_bit;
        ctr_d[bus.arr_id]   = '0;
        mask_d[bus.arr_id]  = '0;
        state_d[bus.arr_id] = IDLE;
      end else begin
        ctr_d[bus.arr_id]   = ctr_q[bus.arr_id] + NW_WIDTH'(1);
        mask_d[bus.arr_id]  = mask_q[bus.arr_id] | arr_bit;
        state_d[bus.arr_id] = COLLECT;
      end
    end

`ifdef BAR_GLOBAL_EN
    if (req_fire) begin
      state_d[req_id_q] = GWAIT;
    end

    if (bus.gbar_rsp_valid) begin
      if (state_q[bus.gbar_rsp_id] == GWAIT) begin
        release_mask_d          = release_mask_d | mask_q[bus.gbar_rsp_id];
        ctr_d[bus.gbar_rsp_id]   = '0;
        mask_d[bus.gbar_rsp_id]  = '0;
        state_d[bus.gbar_rsp_id] = IDLE;
      end else begin
        err_set = 1'b1;
      end
    end

    // Arbitrate on next-state so a freshly completed barrier is requested without a bubble;
    // an issued request is held unchanged until it fires.
    for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
      if (state_d[b] == GWAIT) any_wait = 1'b1;
      if (state_d[b] == GREQ) begin
        any_greq = 1'b1;
        greq_sel = NB_WIDTH'(b);
      end
    end
    if (!req_valid_q || req_fire) begin
      req_valid_d = any_greq && !any_wait;
      if (any_greq && !any_wait) begin
        req_id_d   = greq_sel;
        req_size_d = size_d[greq_sel];
      end
    end
`endif

    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (state_d[b] != IDLE) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= '{default: IDLE};
      ctr_q           <= '{default: '0};
      mask_q          <= '{default: '0};
      release_mask_q  <= '0;
      release_valid_q <= 1'b0;
      error_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ctr_q           <= ctr_d;
      mask_q          <= mask_d;
      release_mask_q  <= release_mask_d;
      release_valid_q <= (release_mask_d != '0);
      error_q         <= error_q | err_set;
      busy_q          <= busy_d;
    end
  end

`ifdef BAR_GLOBAL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q      <= '{default: '0};
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      req_size_q  <= '0;
    end else begin
      size_q      <= size_d;
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
      req_size_q  <= req_size_d;
    end
  end

  assign bus.gbar_req_valid   = req_valid_q;
  assign bus.gbar_req_id      = req_id_q;
  assign bus.gbar_req_size_m1 = req_size_q;
  assign bus.gbar_req_core_id = NC_WIDTH'(CORE_ID % NUM_CORES);
`else
  assign bus.gbar_req_valid   = 1'b0;
  assign bus.gbar_req_id      = {NB_WIDTH{1'b0}};
  assign bus.gbar_req_size_m1 = {NC_WIDTH{1'b0}};
  assign bus.gbar_req_core_id = {NC_WIDTH{1'b0}};
`endif

  assign bus.release_valid = release_valid_q;
  assign bus.release_mask  = release_mask_q;
  assign bus.error         = error_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_warp_barrier_ctrl.sv
// Bench for warp_barrier_ctrl: vector table, hand sequences (global ones under BAR_GLOBAL_EN),
// and random local/noop traffic against a list-based model of barrier membership.
module tb_warp_barrier_ctrl;
  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;
  localparam int NUM_CORES    = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  warp_barrier_ctrl_if #(.NUM_WARPS(NUM_WARPS), .NUM_BARRIERS(NUM_BARRIERS),
                         .NUM_CORES(NUM_CORES)) bus ();

  warp_barrier_ctrl #(.NUM_WARPS(NUM_WARPS), .NUM_BARRIERS(NUM_BARRIERS),
                      .NUM_CORES(NUM_CORES), .CORE_ID(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       v;
    logic       noop;
    logic [1:0] wid;
    logic [1:0] id;
    logic [1:0] sz;
    logic [3:0] rel;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  // reference model state: list of warps that have arrived at each barrier
  int   lst [NUM_BARRIERS][NUM_WARPS];
  int   cnt [NUM_BARRIERS];
  logic m_err;
  int   sz_tab [NUM_BARRIERS];

  function automatic vec_t mkv(logic v, logic noop, int w, int b, int s,
                               logic [3:0] rel, logic busy, logic err);
    vec_t r;
    r.v = v; r.noop = noop; r.wid = 2'(w); r.id = 2'(b); r.sz = 2'(s);
    r.rel = rel; r.busy = busy; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arr_valid      = 1'b0;
    bus.arr_wid        = '0;
    bus.arr_id         = '0;
    bus.arr_size_m1    = '0;
    bus.arr_is_global  = 1'b0;
    bus.arr_is_noop    = 1'b0;
    bus.active_warps   = 4'b0011;
    bus.gbar_req_ready = 1'b0;
    bus.gbar_rsp_valid = 1'b0;
    bus.gbar_rsp_id    = '0;
  endtask

  task automatic arrive(input logic v, input logic noop, input logic glob,
                        input int w, input int b, input int s);
    bus.arr_valid     = v;
    bus.arr_is_noop   = noop;
    bus.arr_is_global = glob;
    bus.arr_wid       = 2'(w);
    bus.arr_id        = 2'(b);
    bus.arr_size_m1   = 2'(s);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] rel,
                            input logic busy_e, input logic err_e);
    chk({tag, ".release_mask"}, 32'(bus.release_mask), 32'(rel));
    chk({tag, ".release_valid"}, 32'(bus.release_valid), 32'(rel != 4'b0));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy_e));
    chk({tag, ".error"}, 32'(bus.error), 32'(err_e));
  endtask

  task automatic check_req(input string tag, input logic v, input int id, input int sz);
    chk({tag, ".gbar_req_valid"}, 32'(bus.gbar_req_valid), 32'(v));
    if (v) begin
      chk({tag, ".gbar_req_id"}, 32'(bus.gbar_req_id), 32'(id));
      chk({tag, ".gbar_req_size_m1"}, 32'(bus.gbar_req_size_m1), 32'(sz));
      chk({tag, ".gbar_req_core_id"}, 32'(bus.gbar_req_core_id), 32'd0);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rel;
    logic       v, noop, glob, dup, m_busy;
    int         w, b, s;

    reset = 1'b0;
    do_reset();
    check_outs("reset", 4'b0, 1'b0, 1'b0);
    check_req("reset", 1'b0, 0, 0);

    // one vector per cycle: expected outputs are those visible right after that cycle
    tbl.push_back(mkv(1, 0, 0, 1, 3, 4'b0000, 1, 0));
    tbl.push_back(mkv(1, 0, 1, 1, 3, 4'b0000, 1, 0));
    tbl.push_back(mkv(1, 0, 2, 1, 3, 4'b0000, 1, 0));
    tbl.push_back(mkv(1, 0, 3, 1, 3, 4'b1111, 0, 0));
    tbl.push_back(mkv(1, 1, 2, 1, 3, 4'b0100, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 2, 1, 4'b0000, 1, 0));
    tbl.push_back(mkv(1, 1, 0, 2, 3, 4'b0001, 1, 0));
    tbl.push_back(mkv(1, 0, 1, 2, 1, 4'b0011, 0, 0));
    tbl.push_back(mkv(1, 0, 2, 3, 0, 4'b0100, 0, 0));
    tbl.push_back(mkv(1, 0, 2, 3, 0, 4'b0100, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 2, 1, 4'b0000, 1, 0));
    tbl.push_back(mkv(1, 0, 1, 2, 1, 4'b0011, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 2, 1, 4'b0000, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 2, 1, 4'b0011, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 1, 4'b0000, 1, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 1, 4'b0000, 1, 1));
    tbl.push_back(mkv(1, 0, 0, 0, 1, 4'b0011, 0, 1));

    foreach (tbl[i]) begin
      arrive(tbl[i].v, tbl[i].noop, 1'b0, int'(tbl[i].wid), int'(tbl[i].id), int'(tbl[i].sz));
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].rel, tbl[i].busy, tbl[i].err);
      check_req($sformatf("vec%0d", i), 1'b0, 0, 0);
    end

`ifdef BAR_GLOBAL_EN
    do_reset();
    bus.active_warps = 4'b0011;
    arrive(1, 0, 1, 0, 0, 0); tick(); check_req("g_c1", 1'b0, 0, 0);
    arrive(1, 0, 1, 1, 0, 0); tick(); check_req("g_c2", 1'b1, 0, 0);
    arrive(1, 0, 1, 0, 2, 1); tick(); check_req("g_c3", 1'b1, 0, 0);
    arrive(1, 0, 1, 1, 2, 1); tick(); check_req("g_c4", 1'b1, 0, 0);
    arrive(0, 0, 0, 0, 0, 0); tick(); check_req("g_hold", 1'b1, 0, 0);
    check_outs("g_hold", 4'b0, 1'b1, 1'b0);
    bus.gbar_req_ready = 1'b1; tick(); check_req("g_fire0", 1'b0, 0, 0);
    bus.gbar_req_ready = 1'b0; tick(); check_req("g_wait0", 1'b0, 0, 0);
    bus.gbar_rsp_valid = 1'b1; bus.gbar_rsp_id = 2'd0; tick();
    check_outs("g_rsp0", 4'b0011, 1'b1, 1'b0);
    check_req("g_rsp0", 1'b1, 2, 1);
    bus.gbar_rsp_valid = 1'b0; bus.gbar_req_ready = 1'b1; tick();
    check_req("g_fire2", 1'b0, 0, 0);
    bus.gbar_req_ready = 1'b0;
    bus.gbar_rsp_valid = 1'b1; bus.gbar_rsp_id = 2'd2;
    arrive(1, 0, 0, 2, 1, 0); tick();
    check_outs("g_same_cycle", 4'b0111, 1'b0, 1'b0);
    bus.gbar_rsp_valid = 1'b0;
    arrive(1, 0, 1, 0, 3, 0); tick();
    arrive(1, 0, 1, 1, 3, 0); tick(); check_req("g_req3", 1'b1, 3, 0);
    arrive(0, 0, 0, 0, 0, 0); bus.gbar_req_ready = 1'b1; tick();
    bus.gbar_req_ready = 1'b0;
    check_outs("g_gwait3", 4'b0, 1'b1, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    check_req("g_midreset", 1'b0, 0, 0);
    check_outs("g_midreset", 4'b0, 1'b0, 1'b0);
    bus.gbar_rsp_valid = 1'b1; bus.gbar_rsp_id = 2'd3; tick();
    bus.gbar_rsp_valid = 1'b0;
    check_outs("g_stale_rsp", 4'b0, 1'b0, 1'b1);
`else
    do_reset();
    arrive(1, 0, 1, 0, 0, 1); tick();
    check_outs("nog_c1", 4'b0, 1'b1, 1'b0);
    arrive(1, 0, 1, 1, 0, 1);
    bus.gbar_rsp_valid = 1'b1; bus.gbar_rsp_id = 2'd0; bus.gbar_req_ready = 1'b1; tick();
    check_outs("nog_c2", 4'b0011, 1'b0, 1'b0);
    check_req("nog_c2", 1'b0, 0, 0);
    bus.gbar_rsp_valid = 1'b0; bus.gbar_req_ready = 1'b0;
`endif

    sz_tab[0] = 2; sz_tab[1] = 3; sz_tab[2] = 1; sz_tab[3] = 0;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      m_err = 1'b0;
      for (int k = 0; k < NUM_BARRIERS; k++) cnt[k] = 0;
      check_outs("rnd_reset", 4'b0, 1'b0, 1'b0);
      for (int cyc = 0; cyc < 150; cyc++) begin
        v    = ($urandom_range(0, 9) < 7);
        noop = ($urandom_range(0, 9) < 2);
        w    = int'($urandom_range(0, 3));
        b    = int'($urandom_range(0, 3));
        s    = sz_tab[b];
        if ($urandom_range(0, 9) == 0) s = int'($urandom_range(0, 3));
`ifdef BAR_GLOBAL_EN
        glob = 1'b0;
`else
        glob = 1'($urandom_range(0, 1));
`endif
        arrive(v, noop, glob, w, b, s);

        exp_rel = 4'b0;
        if (v) begin
          if (noop) begin
            exp_rel[w] = 1'b1;
          end else begin
            dup = 1'b0;
            for (int i = 0; i < cnt[b]; i++) if (lst[b][i] == w) dup = 1'b1;
            if (dup) begin
              m_err = 1'b1;
            end else if (cnt[b] == s) begin
              for (int i = 0; i < cnt[b]; i++) exp_rel[lst[b][i]] = 1'b1;
              exp_rel[w] = 1'b1;
              cnt[b] = 0;
            end else begin
              lst[b][cnt[b]] = w;
              cnt[b]++;
            end
          end
        end
        m_busy = 1'b0;
        for (int k = 0; k < NUM_BARRIERS; k++) if (cnt[k] > 0) m_busy = 1'b1;

        tick();
        check_outs($sformatf("rnd%0d_%0d", seg, cyc), exp_rel, m_busy, m_err);
        chk("rnd.gbar_req_valid", 32'(bus.gbar_req_valid), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
